// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweep controller.
package tt_sweep_pkg;

  localparam int TT_W  = 8;
  localparam int VEC_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    REPORT = 2'd3
  } state_t;

  // Vector 000 lands in the MSB of the truth-table code.
  function automatic logic [VEC_W-1:0] tt_bit_index(input logic [VEC_W-1:0] v);
    return VEC_W'(TT_W - 1) - v;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Settle-time counter: counts while enabled, flags the last settle cycle.
module tt_settle_timer
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expire = i_en && (r_cnt == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Sweeps all 8 input vectors of a 3-input gate and assembles its truth-table code.
//   state  | meaning
//   IDLE   | waiting for start; gate_in parked at 000
//   SETTLE | vector applied, waiting SETTLE_CYCLES cycles
//   SAMPLE | capture gate_out into table_q at the closing edge
//   REPORT | one-cycle done pulse with pass/fail_mask valid
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic [7:0] i_expected,
  input  logic       i_gate_out,
  output logic [2:0] o_gate_in,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_table_q,
  output logic       o_pass,
  output logic [7:0] o_fail_mask
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [VEC_W-1:0]  r_vec;
  logic [TT_W-1:0]   r_table;
  logic [TT_W-1:0]   r_exp;
  logic              r_pass;
  logic [TT_W-1:0]   r_fail_mask;
  logic [TT_W-1:0]   w_table_cap;
  logic              w_accept;
  logic              w_last_vec;
  logic              w_expire;

  assign w_accept   = (r_state == IDLE) && i_start && !i_abort;
  assign w_last_vec = (r_vec == VEC_W'(TT_W - 1));

  tt_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (r_state != SETTLE),
    .i_en    (r_state == SETTLE),
    .o_expire(w_expire)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = SETTLE;
      SETTLE: begin
        if (i_abort)       w_state_nxt = IDLE;
        else if (w_expire) w_state_nxt = SAMPLE;
      end
      SAMPLE: begin
        if (i_abort)         w_state_nxt = IDLE;
        else if (w_last_vec) w_state_nxt = REPORT;
        else                 w_state_nxt = SETTLE;
      end
      REPORT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Table including the bit being captured this cycle, so pass/fail see all 8 bits.
  always_comb begin
    w_table_cap = r_table;
    w_table_cap[tt_bit_index(r_vec)] = i_gate_out;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_vec       <= '0;
      r_table     <= '0;
      r_exp       <= '0;
      r_pass      <= 1'b0;
      r_fail_mask <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_exp   <= i_expected;
            r_table <= '0;
            r_vec   <= '0;
          end
        end
        SETTLE: begin
          if (i_abort) r_vec <= '0;
        end
        SAMPLE: begin
          if (i_abort) begin
            r_vec <= '0;
          end else begin
            r_table <= w_table_cap;
            if (w_last_vec) begin
              r_vec       <= '0;
              r_pass      <= (w_table_cap == r_exp);
              r_fail_mask <= w_table_cap ^ r_exp;
            end else begin
              r_vec <= r_vec + VEC_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_gate_in   = r_vec;
  assign o_busy      = (r_state != IDLE);
  assign o_done      = (r_state == REPORT);
  assign o_table_q   = r_table;
  assign o_pass      = r_pass;
  assign o_fail_mask = r_fail_mask;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Randomized self-checking bench for tt_sweep_ctrl against a cycle-count reference model.
module tb_tt_sweep_ctrl;

  localparam int S     = 4;
  localparam int PER   = S + 1;
  localparam int SWEEP = 8 * PER;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] expected;
  logic       gate_out;
  logic [2:0] gate_in;
  logic       busy;
  logic       done;
  logic [7:0] table_q;
  logic       pass;
  logic [7:0] fail_mask;

  bit g_fn [8];
  bit glitch;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign gate_out = g_fn[gate_in] ^ glitch;

  tt_sweep_ctrl #(
    .SETTLE_CYCLES(S),
    .CNT_W        (16)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_abort    (abort),
    .i_expected (expected),
    .i_gate_out (gate_out),
    .o_gate_in  (gate_in),
    .o_busy     (busy),
    .o_done     (done),
    .o_table_q  (table_q),
    .o_pass     (pass),
    .o_fail_mask(fail_mask)
  );

  // lut bit v is the gate output for input vector v
  task automatic set_gate(input logic [7:0] lut);
    for (int v = 0; v < 8; v++) g_fn[v] = lut[v];
  endtask

  function automatic logic [7:0] model_code();
    logic [7:0] c;
    c = 8'h00;
    for (int v = 0; v < 8; v++) c[7-v] = g_fn[v];
    return c;
  endfunction

  task automatic run_sweep(input logic [7:0] exp_code, input bit glitch_en, input int restart_k);
    logic [7:0] mdl;
    logic [7:0] part;
    int v;
    mdl = model_code();
    @(negedge clk);
    start = 1'b1;
    expected = exp_code;
    @(posedge clk);
    for (int k = 0; k < SWEEP; k++) begin
      @(negedge clk);
      start = (k == restart_k);
      if (start) expected = ~exp_code;
      v = k / PER;
      part = 8'h00;
      for (int u = 0; u < v; u++) part[7-u] = mdl[7-u];
      checks++;
      if (gate_in !== 3'(v)) begin
        errors++; $display("FAIL gate_in k=%0d: got %0d want %0d", k, gate_in, v);
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++; $display("FAIL busy k=%0d: got %b want 1", k, busy);
      end
      checks++;
      if (done !== 1'b0) begin
        errors++; $display("FAIL early_done k=%0d: got %b want 0", k, done);
      end
      checks++;
      if (table_q !== part) begin
        errors++; $display("FAIL partial_table k=%0d: got %h want %h", k, table_q, part);
      end
      glitch = (glitch_en && (k % PER != PER - 1)) ? 1'($urandom) : 1'b0;
    end
    @(negedge clk);
    start = 1'b0;
    glitch = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL done_at_%0d: got %b want 1", SWEEP, done);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL busy_report: got %b want 1", busy);
    end
    checks++;
    if (gate_in !== 3'd0) begin
      errors++; $display("FAIL gate_in_report: got %0d want 0", gate_in);
    end
    checks++;
    if (table_q !== mdl) begin
      errors++; $display("FAIL table_q: got %h want %h", table_q, mdl);
    end
    checks++;
    if (pass !== (mdl == exp_code)) begin
      errors++; $display("FAIL pass: got %b want %b", pass, (mdl == exp_code));
    end
    checks++;
    if (fail_mask !== (mdl ^ exp_code)) begin
      errors++; $display("FAIL fail_mask: got %h want %h", fail_mask, mdl ^ exp_code);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL after_report: got done=%b busy=%b want 0 0", done, busy);
    end
    checks++;
    if (pass !== (mdl == exp_code) || fail_mask !== (mdl ^ exp_code)) begin
      errors++; $display("FAIL result_hold: got pass=%b mask=%h want %b %h",
                         pass, fail_mask, (mdl == exp_code), mdl ^ exp_code);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; expected = 8'h00; glitch = 1'b0;
    set_gate(8'h00);
    repeat (2) @(negedge clk);
    checks++;
    if (gate_in !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: got gate_in=%0d busy=%b done=%b want 0 0 0", gate_in, busy, done);
    end
    checks++;
    if (table_q !== 8'h00 || pass !== 1'b0 || fail_mask !== 8'h00) begin
      errors++; $display("FAIL reset_result: got table=%h pass=%b mask=%h want 00 0 00", table_q, pass, fail_mask);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    set_gate(8'h9B);               // outputs 1,1,0,1,1,0,0,1 for v=0..7
    run_sweep(8'hD9, 1'b0, -1);
    run_sweep(8'hD8, 1'b0, -1);
  endtask

  task automatic test_constant();
    set_gate(8'hFF);
    run_sweep(8'hFF, 1'b0, -1);
    set_gate(8'h00);
    run_sweep(8'h00, 1'b0, -1);
  endtask

  task automatic test_abort();
    set_gate(8'h9B);
    run_sweep(8'hD8, 1'b0, -1);    // leaves pass=0, fail_mask=01
    @(negedge clk);
    start = 1'b1; expected = 8'hD9;
    @(posedge clk);
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      start = 1'b0;
      abort = (k == 16);
    end
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || gate_in !== 3'd0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_ctrl: got busy=%b gate_in=%0d done=%b want 0 0 0", busy, gate_in, done);
    end
    checks++;
    if (table_q !== 8'hC0) begin
      errors++; $display("FAIL abort_partial: got %h want c0", table_q);
    end
    checks++;
    if (pass !== 1'b0 || fail_mask !== 8'h01) begin
      errors++; $display("FAIL abort_hold: got pass=%b mask=%h want 0 01", pass, fail_mask);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL abort_quiet k=%0d: got done=%b busy=%b want 0 0", k, done, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    set_gate(8'h9B);
    run_sweep(8'hD9, 1'b0, 10);    // start pulse at cycle 10 must be ignored
    @(negedge clk);
    start = 1'b1; abort = 1'b1; expected = 8'h00;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (busy !== 1'b0 || gate_in !== 3'd0) begin
        errors++; $display("FAIL start_abort k=%0d: got busy=%b gate_in=%0d want 0 0", k, busy, gate_in);
      end
      @(negedge clk);
    end
    checks++;
    if (pass !== 1'b1 || fail_mask !== 8'h00) begin
      errors++; $display("FAIL start_abort_hold: got pass=%b mask=%h want 1 00", pass, fail_mask);
    end
  endtask

  task automatic test_async_rst();
    set_gate(8'h9B);
    run_sweep(8'hD9, 1'b0, -1);
    @(negedge clk);
    start = 1'b1; expected = 8'hD9;
    @(posedge clk);
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;                    // mid-cycle of vector 1's SAMPLE
    #1;
    checks++;
    if (gate_in !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL async_rst_ctrl: got gate_in=%0d busy=%b done=%b want 0 0 0", gate_in, busy, done);
    end
    checks++;
    if (table_q !== 8'h00 || pass !== 1'b0 || fail_mask !== 8'h00) begin
      errors++; $display("FAIL async_rst_result: got table=%h pass=%b mask=%h want 00 0 00", table_q, pass, fail_mask);
    end
    @(negedge clk);
    rst = 1'b0;
    run_sweep(8'hD9, 1'b0, -1);
  endtask

  task automatic test_random();
    logic [7:0] exp_code;
    for (int n = 0; n < 6; n++) begin
      for (int v = 0; v < 8; v++) g_fn[v] = 1'($urandom);
      exp_code = ($urandom_range(0, 1) == 1) ? model_code() : 8'($urandom);
      run_sweep(exp_code, 1'b1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_constant();
    test_abort();
    test_back_to_back();
    test_async_rst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
